// File: rtl/ram_sp_bytewr.sv
// ============================================================================
//  Module   : ram_sp_bytewr
//  Purpose  : Parametrised single-port synchronous RAM with per-byte write
//             enables, write-first bypass of the deferred write, and a
//             hardware clear engine that zeroes every word while busy=1.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1    clock, rising edge
//    resetb   in   1    synchronous active-low reset
//    address  in   AW   word address of request
//    din      in   DW   write data
//    be       in   NB   byte write enables (bit i -> din[8i+7:8i])
//    cs       in   1    request strobe
//    rnw      in   1    1 = read, 0 = write
//    clr      in   1    single-cycle full-memory clear request
//    dout     out  DW   read data (combinational from registered address)
//    perr     out  1    parity error on read (only with RAM_PARITY_EN)
//    busy     out  1    clear in progress, requests are ignored
//  Build option
//    RAM_PARITY_EN : adds one even-parity bit per stored byte and perr port.
// ============================================================================
`default_nettype none

module ram_sp_bytewr #(
  parameter int AW             = 13,
  parameter int DW             = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic [AW-1:0]      address,
  input  logic [DW-1:0]      din,
  input  logic [DW/8-1:0]    be,
  input  logic               cs,
  input  logic               rnw,
  input  logic               clr,
  output logic [DW-1:0]      dout,
`ifdef RAM_PARITY_EN
  output logic               perr,
`endif
  output logic               busy
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_CLEAR = 1'b1;
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [DW-1:0] mem_q [0:DEPTH-1];

  logic [0:0]    state_q,   state_d;
  logic [AW:0]   cnt_q,     cnt_d;
  logic          cs_q,      cs_d;
  logic          rnw_q,     rnw_d;
  logic [AW-1:0] address_q, address_d;
  logic          wr_pend_q, wr_pend_d;
  logic [DW-1:0] din_q,     din_d;
  logic [NB-1:0] be_q,      be_d;

  logic          accept;

  assign busy   = (state_q == ST_CLEAR);
  // clr wins over cs on the same edge.
  assign accept = cs & ~busy & ~clr;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cs_d      = accept;
    rnw_d     = accept ? rnw     : rnw_q;
    address_d = accept ? address : address_q;
    din_d     = accept ? din     : din_q;
    be_d      = accept ? be      : be_q;
    // A new write re-arms the pending flag on the same edge the old one commits.
    wr_pend_d = accept & ~rnw;

    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q     <= '0;
      cs_q      <= 1'b0;
      rnw_q     <= 1'b0;
      address_q <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cs_q      <= cs_d;
      rnw_q     <= rnw_d;
      address_q <= address_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  // Write payload needs no reset: it is only consumed while wr_pend_q=1.
  always_ff @(posedge clk) begin
    din_q <= din_d;
    be_q  <= be_d;
  end

  // --------------------------------------------------------------------------
  // Storage. A write pending at the clr edge commits on that edge; the clear
  // engine only starts writing on the following edge, so the two never collide.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (resetb) begin
      if (wr_pend_q) begin
        for (int i = 0; i < NB; i++) begin
          if (be_q[i]) begin
            mem_q[address_q][8*i +: 8] <= din_q[8*i +: 8];
          end
        end
      end
      if (state_q == ST_CLEAR) begin
        mem_q[cnt_q[AW-1:0]] <= '0;
      end
    end
  end

  // Write-first bypass: enabled lanes of the pending write override memory.
  always_comb begin
    dout = mem_q[address_q];
    if (wr_pend_q) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) begin
          dout[8*i +: 8] = din_q[8*i +: 8];
        end
      end
    end
  end

`ifdef RAM_PARITY_EN
  // Even parity per byte: stored bit equals XOR of the byte, so an all-zero
  // cleared byte carries parity 0.
  logic [NB-1:0] par_q [0:DEPTH-1];
  logic [NB-1:0] par_bad;

  always_ff @(posedge clk) begin
    if (resetb) begin
      if (wr_pend_q) begin
        for (int i = 0; i < NB; i++) begin
          if (be_q[i]) begin
            par_q[address_q][i] <= ^din_q[8*i +: 8];
          end
        end
      end
      if (state_q == ST_CLEAR) begin
        par_q[cnt_q[AW-1:0]] <= '0;
      end
    end
  end

  always_comb begin
    par_bad = '0;
    for (int i = 0; i < NB; i++) begin
      par_bad[i] = (^mem_q[address_q][8*i +: 8]) ^ par_q[address_q][i];
    end
  end

  assign perr = cs_q & rnw_q & ~wr_pend_q & (|par_bad);
`endif

endmodule

`default_nettype wire
